// File: rtl/final_proj_soc_timer_seq.sv
// -----------------------------------------------------------------------------
// final_proj_soc_timer_seq
//
// Avalon-MM master that drives a 16-bit interval-timer slave. The timer has
// six registers: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l and
// 5 snap_h. This block:
//   - programs the period and mode, then starts the timer
//   - services the timer interrupt by clearing status, and emits one tick
//     for every serviced timeout
//   - captures a 32-bit counter snapshot on request
//   - stops the timer on request
//
// Ports
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_start               pulse: program period/mode and start the timer
//   i_period[31:0]        timer load value, latched when start is accepted
//   i_continuous          1 = periodic, 0 = one-shot, latched with period
//   i_stop                pulse: stop the timer
//   i_snap_req            pulse: capture a counter snapshot
//   o_busy                sequencer is not idle
//   o_running             timer started and not yet stopped or expired
//   o_cfg_err             pulse: start rejected because period < PERIOD_MIN
//   o_tick                pulse for each serviced timeout
//   o_tick_count          count of serviced timeouts, wraps
//   o_snap_valid          pulse: o_snap_value has just been updated
//   o_snap_value[31:0]    last snapshot {snap_h, snap_l}
//   o_avm_*               Avalon-MM master interface to the timer slave
//   i_avm_readdata[15:0]  read data; the slave registers it (1-cycle latency)
//   i_timer_irq           timer interrupt, level, held until status is written
// -----------------------------------------------------------------------------
module final_proj_soc_timer_seq #(
   parameter int          TICK_CNT_W = 16,
   parameter logic [31:0] PERIOD_MIN = 32'd2
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [31:0]           i_period,
   input  logic                  i_continuous,
   input  logic                  i_stop,
   input  logic                  i_snap_req,
   output logic                  o_busy,
   output logic                  o_running,
   output logic                  o_cfg_err,
   output logic                  o_tick,
   output logic [TICK_CNT_W-1:0] o_tick_count,
   output logic                  o_snap_valid,
   output logic [31:0]           o_snap_value,
   output logic [2:0]            o_avm_address,
   output logic                  o_avm_chipselect,
   output logic                  o_avm_write_n,
   output logic [15:0]           o_avm_writedata,
   input  logic [15:0]           i_avm_readdata,
   input  logic                  i_timer_irq
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_WR_PL   = 4'd1;
   localparam logic [3:0] S_WR_PH   = 4'd2;
   localparam logic [3:0] S_WR_CTRL = 4'd3;
   localparam logic [3:0] S_RUN     = 4'd4;
   localparam logic [3:0] S_CLR_ST  = 4'd5;
   localparam logic [3:0] S_WR_SNAP = 4'd6;
   localparam logic [3:0] S_RD_SNL  = 4'd7;
   localparam logic [3:0] S_CAP_SNL = 4'd8;
   localparam logic [3:0] S_RD_SNH  = 4'd9;
   localparam logic [3:0] S_CAP_SNH = 4'd10;
   localparam logic [3:0] S_WR_STOP = 4'd11;

   localparam logic [TICK_CNT_W-1:0] TICK_ONE = {{(TICK_CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]            r_state;
   logic [3:0]            w_state_next;
   logic [31:0]           r_period;
   logic                  r_cont;
   logic                  r_pend_snap;
   logic                  r_pend_stop;
   logic                  r_running;
   logic                  r_cfg_err;
   logic [TICK_CNT_W-1:0] r_tick_count;
   logic [15:0]           r_snap_lo;
   logic [31:0]           r_snap_value;
   logic                  r_snap_valid;

   // A request arriving in the same cycle that RUN decides is acted on
   // at once, so it does not have to wait a cycle in the pending flag.
   logic w_stop;
   logic w_snap;
   logic w_start_ok;
   logic w_start_bad;

   assign w_stop      = r_pend_stop | i_stop;
   assign w_snap      = r_pend_snap | i_snap_req;
   assign w_start_ok  = i_start && (i_period >= PERIOD_MIN);
   assign w_start_bad = i_start && (i_period <  PERIOD_MIN);

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (w_start_ok) w_state_next = S_WR_PL;
         S_WR_PL:   w_state_next = S_WR_PH;
         S_WR_PH:   w_state_next = S_WR_CTRL;
         S_WR_CTRL: w_state_next = S_RUN;
         S_RUN: begin
            if (w_stop)           w_state_next = S_WR_STOP;
            else if (i_timer_irq) w_state_next = S_CLR_ST;
            else if (w_snap)      w_state_next = S_WR_SNAP;
         end
         S_CLR_ST:  w_state_next = r_cont ? S_RUN : S_IDLE;
         S_WR_SNAP: w_state_next = S_RD_SNL;
         S_RD_SNL:  w_state_next = S_CAP_SNL;
         S_CAP_SNL: w_state_next = S_RD_SNH;
         S_RD_SNH:  w_state_next = S_CAP_SNH;
         S_CAP_SNH: w_state_next = S_RUN;
         S_WR_STOP: w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // Bus decode: the access belonging to a state is presented during that state.
   // CAP states leave the bus idle while the registered read data is sampled.
   always_comb begin
      o_avm_chipselect = 1'b0;
      o_avm_write_n    = 1'b1;
      o_avm_address    = 3'd0;
      o_avm_writedata  = 16'h0000;
      case (r_state)
         S_WR_PL: begin
            o_avm_chipselect = 1'b1;
            o_avm_write_n    = 1'b0;
            o_avm_address    = 3'd2;
            o_avm_writedata  = r_period[15:0];
         end
         S_WR_PH: begin
            o_avm_chipselect = 1'b1;
            o_avm_write_n    = 1'b0;
            o_avm_address    = 3'd3;
            o_avm_writedata  = r_period[31:16];
         end
         S_WR_CTRL: begin
            // Control: bit2 START, bit1 CONT, bit0 ITO
            o_avm_chipselect = 1'b1;
            o_avm_write_n    = 1'b0;
            o_avm_address    = 3'd1;
            o_avm_writedata  = {12'b0, 1'b0, 1'b1, r_cont, 1'b1};
         end
         S_CLR_ST: begin
            o_avm_chipselect = 1'b1;
            o_avm_write_n    = 1'b0;
            o_avm_address    = 3'd0;
         end
         S_WR_SNAP: begin
            // Any write to snap_l freezes the counter into the snap registers
            o_avm_chipselect = 1'b1;
            o_avm_write_n    = 1'b0;
            o_avm_address    = 3'd4;
         end
         S_RD_SNL: begin
            o_avm_chipselect = 1'b1;
            o_avm_address    = 3'd4;
         end
         S_RD_SNH: begin
            o_avm_chipselect = 1'b1;
            o_avm_address    = 3'd5;
         end
         S_WR_STOP: begin
            // Control: bit3 STOP
            o_avm_chipselect = 1'b1;
            o_avm_write_n    = 1'b0;
            o_avm_address    = 3'd1;
            o_avm_writedata  = 16'h0008;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_period     <= 32'd0;
         r_cont       <= 1'b0;
         r_pend_snap  <= 1'b0;
         r_pend_stop  <= 1'b0;
         r_running    <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_tick_count <= '0;
         r_snap_lo    <= 16'h0000;
         r_snap_value <= 32'd0;
         r_snap_valid <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cfg_err    <= (r_state == S_IDLE) && w_start_bad;
         r_snap_valid <= (r_state == S_CAP_SNH);

         if (r_state == S_IDLE && w_start_ok) begin
            r_period <= i_period;
            r_cont   <= i_continuous;
         end

         // Returning to IDLE drops anything still pending (stop or one-shot
         // expiry makes a queued snapshot meaningless).
         if (w_state_next == S_IDLE)
            r_pend_snap <= 1'b0;
         else if (r_state == S_RUN && w_state_next == S_WR_SNAP)
            r_pend_snap <= 1'b0;
         else if (i_snap_req && r_state != S_IDLE)
            r_pend_snap <= 1'b1;

         if (w_state_next == S_IDLE)
            r_pend_stop <= 1'b0;
         else if (r_state == S_RUN && w_state_next == S_WR_STOP)
            r_pend_stop <= 1'b0;
         else if (i_stop && r_state != S_IDLE)
            r_pend_stop <= 1'b1;

         if (r_state == S_WR_CTRL)
            r_running <= 1'b1;
         else if (w_state_next == S_IDLE)
            r_running <= 1'b0;

         if (r_state == S_CLR_ST)
            r_tick_count <= r_tick_count + TICK_ONE;

         if (r_state == S_CAP_SNL)
            r_snap_lo <= i_avm_readdata;
         if (r_state == S_CAP_SNH)
            r_snap_value <= {i_avm_readdata, r_snap_lo};
      end
   end

   assign o_busy       = (r_state != S_IDLE);
   assign o_running    = r_running;
   assign o_cfg_err    = r_cfg_err;
   assign o_tick       = (r_state == S_CLR_ST);
   assign o_tick_count = r_tick_count;
   assign o_snap_valid = r_snap_valid;
   assign o_snap_value = r_snap_value;

endmodule

// File: tb/tb_final_proj_soc_timer_seq.sv
// -----------------------------------------------------------------------------
// tb_final_proj_soc_timer_seq
//
// Scoreboard bench: every stimulus pushes the bus accesses and snapshots it
// should cause; a negedge monitor pops and compares them as the DUT issues
// them. A small timer-slave model returns snapshot data with one cycle of
// read latency and holds the irq until status is written.
// -----------------------------------------------------------------------------
module tb_final_proj_soc_timer_seq;

   localparam int TCW = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           start, continuous, stop, snap_req;
   logic [31:0]    period;
   logic           busy, running, cfg_err, tick, snap_valid;
   logic [TCW-1:0] tick_count;
   logic [31:0]    snap_value;
   logic [2:0]     avm_address;
   logic           avm_chipselect, avm_write_n;
   logic [15:0]    avm_writedata;
   logic [15:0]    avm_readdata;
   logic           timer_irq;

   final_proj_soc_timer_seq #(.TICK_CNT_W(TCW), .PERIOD_MIN(32'd2)) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_start          (start),
      .i_period         (period),
      .i_continuous     (continuous),
      .i_stop           (stop),
      .i_snap_req       (snap_req),
      .o_busy           (busy),
      .o_running        (running),
      .o_cfg_err        (cfg_err),
      .o_tick           (tick),
      .o_tick_count     (tick_count),
      .o_snap_valid     (snap_valid),
      .o_snap_value     (snap_value),
      .o_avm_address    (avm_address),
      .o_avm_chipselect (avm_chipselect),
      .o_avm_write_n    (avm_write_n),
      .o_avm_writedata  (avm_writedata),
      .i_avm_readdata   (avm_readdata),
      .i_timer_irq      (timer_irq)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_tick = 0;
   int exp_ticks = 0;

   // {write_n, address, writedata}
   logic [19:0] exp_bus[$];
   logic [31:0] exp_snap[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- timer slave model ----------------
   logic [15:0] slv_snap_l = 16'h0;
   logic [15:0] slv_snap_h = 16'h0;
   logic        irq_raise = 1'b0;

   initial begin
      avm_readdata = 16'h0;
      timer_irq    = 1'b0;
   end

   always @(posedge clk) begin
      if (avm_chipselect && avm_write_n)
         avm_readdata <= (avm_address == 3'd4) ? slv_snap_l :
                         (avm_address == 3'd5) ? slv_snap_h : 16'h0;
      if (avm_chipselect && !avm_write_n && avm_address == 3'd0)
         timer_irq <= 1'b0;
      else if (irq_raise)
         timer_irq <= 1'b1;
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (tick) n_tick++;
      if (avm_chipselect) begin
         if (exp_bus.size() == 0)
            check("bus_unexp", {12'h0, avm_write_n, avm_address, avm_writedata}, 32'hFFFF_FFFF);
         else
            check("bus_access", {12'h0, avm_write_n, avm_address, avm_writedata},
                  {12'h0, exp_bus.pop_front()});
         $display("bus %s addr=%0d data=%h", avm_write_n ? "RD" : "WR", avm_address, avm_writedata);
      end
      if (snap_valid) begin
         if (exp_snap.size() == 0)
            check("snap_unexp", snap_value, ~snap_value);
         else
            check("snap_value", snap_value, exp_snap.pop_front());
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input logic [31:0] p, input logic c, input logic with_stop);
      start = 1'b1; period = p; continuous = c; stop = with_stop;
      if (p >= 32'd2) begin
         exp_bus.push_back({1'b0, 3'd2, p[15:0]});
         exp_bus.push_back({1'b0, 3'd3, p[31:16]});
         exp_bus.push_back({1'b0, 3'd1, c ? 16'h0007 : 16'h0005});
      end
      cyc();
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic push_snap(input logic [15:0] lo, input logic [15:0] hi);
      slv_snap_l = lo; slv_snap_h = hi;
      exp_bus.push_back({1'b0, 3'd4, 16'h0000});
      exp_bus.push_back({1'b1, 3'd4, 16'h0000});
      exp_bus.push_back({1'b1, 3'd5, 16'h0000});
      exp_snap.push_back({hi, lo});
   endtask

   task automatic do_irq();
      irq_raise = 1'b1;
      exp_bus.push_back({1'b0, 3'd0, 16'h0000});
      exp_ticks++;
      cyc();
      irq_raise = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; cyc(); stop = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 60 && (exp_bus.size() != 0 || exp_snap.size() != 0); i++) cyc();
      check(tag, exp_bus.size() + exp_snap.size(), 0);
      repeat (3) cyc();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset = 1'b1; start = 1'b0; period = 32'h0; continuous = 1'b0;
      stop = 1'b0; snap_req = 1'b0;
      repeat (3) cyc();
      @(negedge clk);
      check("rst_busy",    busy, 0);
      check("rst_running", running, 0);
      check("rst_cs",      avm_chipselect, 0);
      check("rst_wn",      avm_write_n, 1);
      check("rst_tickcnt", tick_count, 0);
      check("rst_snap",    snap_value, 0);
      reset = 1'b0;
      cyc();

      // program and start periodic timer: three back-to-back writes
      do_start(32'h0001_86A0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("prog_cs", avm_chipselect, 1);
         check("prog_run_lo", running, 0);
      end
      @(negedge clk);
      check("prog_running", running, 1);
      cyc();
      drain("drain_prog");

      // four periodic timeouts
      for (int i = 0; i < 4; i++) begin
         do_irq();
         drain("drain_irq");
      end
      check("tick_cnt4", tick_count, 4);
      check("tick_seen4", n_tick, 4);
      check("run_after4", running, 1);

      // 13 more -> 17 total, wraps to 1 in a 4-bit counter
      for (int i = 0; i < 13; i++) begin
         do_irq();
         drain("drain_irq");
      end
      check("tick_wrap", tick_count, exp_ticks % 16);
      check("tick_wrap1", tick_count, 1);

      // snapshot
      push_snap(16'h1234, 16'h0005);
      snap_req = 1'b1; cyc(); snap_req = 1'b0;
      drain("drain_snap");
      check("snap_hold", snap_value, 32'h0005_1234);

      // irq and snap_req seen in the same cycle: status write first
      irq_raise = 1'b1;
      exp_bus.push_back({1'b0, 3'd0, 16'h0000});
      exp_ticks++;
      push_snap(16'hBEEF, 16'hCAFE);
      cyc();
      irq_raise = 1'b0; snap_req = 1'b1; cyc(); snap_req = 1'b0;
      drain("drain_irq_snap");
      check("tick_cnt_is", tick_count, exp_ticks % 16);

      // stop in the middle of a snapshot: sequence completes, then stop write
      push_snap(16'h0F0F, 16'hA5A5);
      snap_req = 1'b1; cyc(); snap_req = 1'b0;
      cyc();
      exp_bus.push_back({1'b0, 3'd1, 16'h0008});
      pulse_stop();
      drain("drain_stop_snap");
      check("stop_running", running, 0);
      check("stop_busy", busy, 0);

      // rejected start: period below minimum
      do_start(32'd1, 1'b1, 1'b0);
      @(negedge clk);
      check("cfg_err_pulse", cfg_err, 1);
      check("cfg_err_busy", busy, 0);
      @(negedge clk);
      check("cfg_err_clear", cfg_err, 0);
      cyc();

      // one-shot at the minimum period
      do_start(32'd2, 1'b0, 1'b0);
      drain("drain_oneshot_prog");
      check("os_running", running, 1);
      do_irq();
      drain("drain_oneshot");
      check("os_run_done", running, 0);
      check("os_busy", busy, 0);
      check("os_tick_cnt", tick_count, exp_ticks % 16);

      // one-shot with a snapshot requested alongside the irq: snapshot dropped
      do_start(32'h0000_0100, 1'b0, 1'b0);
      drain("drain_os2_prog");
      irq_raise = 1'b1;
      exp_bus.push_back({1'b0, 3'd0, 16'h0000});
      exp_ticks++;
      cyc();
      irq_raise = 1'b0; snap_req = 1'b1; cyc(); snap_req = 1'b0;
      drain("drain_os2");
      repeat (8) cyc();
      check("os2_busy", busy, 0);
      check("os2_tick_seen", n_tick, exp_ticks);

      // stop / snap_req in IDLE are ignored
      stop = 1'b1; snap_req = 1'b1; cyc(); stop = 1'b0; snap_req = 1'b0;
      repeat (4) cyc();
      check("idle_ignore", busy, 0);

      // start and stop together in IDLE: start wins
      do_start(32'h0002_0003, 1'b1, 1'b1);
      drain("drain_start_stop");
      check("ss_running", running, 1);
      exp_bus.push_back({1'b0, 3'd1, 16'h0008});
      pulse_stop();
      drain("drain_ss_stop");
      check("ss_stopped", running, 0);

      // reset asserted while in WR_PH
      do_start(32'h0003_0004, 1'b1, 1'b0);
      cyc();
      reset = 1'b1; cyc(); reset = 1'b0;
      exp_bus.delete();
      @(negedge clk);
      check("rst_mid_cs", avm_chipselect, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_wn", avm_write_n, 1);
      check("rst_mid_tick", tick_count, 0);
      repeat (4) cyc();
      check("rst_mid_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
